// File: rtl/phase_array_ctrl.sv
// phase_array_ctrl: CHANNELS phased square-wave drive outputs from one shared
// period counter. Per-channel settings are double-buffered (shadow/active) and
// swapped only at a period boundary. Commands arrive as framed bytes.
// Build option: define PA_CHECKSUM_EN to require a trailing checksum byte.

module pa_chan #(
  parameter int PHASE_W = 11,
  parameter int PERIOD  = 1250
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] cnt,
  input  logic               wr_phase,
  input  logic               wr_duty,
  input  logic               wr_en,
  input  logic [PHASE_W-1:0] wdata,
  input  logic               en_bit,
  input  logic               swap,
  output logic               tx
);
  localparam int PW1 = PHASE_W + 1;
  localparam logic [PHASE_W:0]   PER      = PW1'(PERIOD);
  localparam logic [PHASE_W-1:0] DUTY_RST = PHASE_W'(PERIOD / 2);

  logic [PHASE_W-1:0] sh_phase, sh_duty, ac_phase, ac_duty;
  logic               sh_en, ac_en;
  logic [PHASE_W:0]   d;

  // shadow bank: written by commands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_phase <= '0;
      sh_duty  <= DUTY_RST;
      sh_en    <= 1'b0;
    end else begin
      if (wr_phase) sh_phase <= wdata;
      if (wr_duty)  sh_duty  <= wdata;
      if (wr_en)    sh_en    <= en_bit;
    end
  end

  // active bank: takes the pre-write shadow value on a swap edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ac_phase <= '0;
      ac_duty  <= DUTY_RST;
      ac_en    <= 1'b0;
    end else if (swap) begin
      ac_phase <= sh_phase;
      ac_duty  <= sh_duty;
      ac_en    <= sh_en;
    end
  end

  // position within the period relative to this channel's phase, kept in
  // 0..PERIOD-1 with one spare bit so no intermediate can overflow
  always_comb begin
    if (cnt >= ac_phase) d = {1'b0, cnt} - {1'b0, ac_phase};
    else                 d = PER - ({1'b0, ac_phase} - {1'b0, cnt});
  end

  // registered drive output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx <= 1'b0;
    else      tx <= ac_en & (d < {1'b0, ac_duty});
  end
endmodule

module phase_array_ctrl #(
  parameter int CHANNELS = 88,
  parameter int PHASE_W  = 11,
  parameter int PERIOD   = 1250
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_tdata,
  input  logic                rx_tvalid,
  output logic                rx_tready,
  output logic [7:0]          tx_tdata,
  output logic                tx_tvalid,
  input  logic                tx_tready,
  output logic                sync_out,
  output logic                swap_out,
  output logic [CHANNELS-1:0] tx,
  output logic                err_out
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_B1,
    S_B2,
    S_B3,
`ifdef PA_CHECKSUM_EN
    S_CK,
`endif
    S_EXEC
  } state_t;

  state_t             state, state_d;
  logic [2:0]         op_q;
  logic [6:0]         addr_q, d1_q, d2_q;
  logic [PHASE_W-1:0] cnt;
  logic               swap_pend, wrap, swap_now, rx_fire;
  logic [13:0]        data;
  logic [PHASE_W-1:0] wdata;
  logic               addr_bad, data_bad;
  logic               wr_phase, wr_duty, wr_en, wr_bcast, set_swap;
  logic               resp_vld, fault;
  logic [7:0]         resp_byte;

`ifdef PA_CHECKSUM_EN
  logic [3:0] opl_q;
  logic [6:0] ck_q, ck_sum;
  assign ck_sum = {op_q, opl_q} + addr_q + d1_q + d2_q;
`else
  logic unused_op_low;
  assign unused_op_low = ^rx_tdata[3:0];
`endif

  assign rx_fire   = rx_tvalid & rx_tready;
  assign rx_tready = (state != S_EXEC) & ~tx_tvalid;
  assign data      = {d1_q, d2_q};
  assign wdata     = PHASE_W'(data);
  assign addr_bad  = 32'(addr_q) >= CHANNELS;
  assign data_bad  = 32'(data) >= PERIOD;
  assign wrap      = cnt == PHASE_W'(PERIOD - 1);
  assign swap_now  = swap_pend & wrap;

  // parser state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  // frame field capture; any opcode byte restarts the frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= '0;
      addr_q <= '0;
      d1_q   <= '0;
      d2_q   <= '0;
`ifdef PA_CHECKSUM_EN
      opl_q  <= '0;
      ck_q   <= '0;
`endif
    end else if (rx_fire) begin
      if (rx_tdata[7]) begin
        op_q  <= rx_tdata[6:4];
`ifdef PA_CHECKSUM_EN
        opl_q <= rx_tdata[3:0];
`endif
      end else begin
        case (state)
          S_B1:    addr_q <= rx_tdata[6:0];
          S_B2:    d1_q   <= rx_tdata[6:0];
          S_B3:    d2_q   <= rx_tdata[6:0];
`ifdef PA_CHECKSUM_EN
          S_CK:    ck_q   <= rx_tdata[6:0];
`endif
          default: ;
        endcase
      end
    end
  end

  // next state and one-cycle EXEC command decode
  always_comb begin
    state_d   = state;
    wr_phase  = 1'b0;
    wr_duty   = 1'b0;
    wr_en     = 1'b0;
    wr_bcast  = 1'b0;
    set_swap  = 1'b0;
    resp_vld  = 1'b0;
    resp_byte = 8'h00;
    fault     = 1'b0;
    if (state == S_EXEC) begin
      state_d = S_IDLE;
`ifdef PA_CHECKSUM_EN
      if (ck_q != ck_sum) begin
        fault     = 1'b1;
        resp_vld  = 1'b1;
        resp_byte = 8'hFD;
      end else
`endif
      begin
        case (op_q)
          3'd0:    if (addr_bad | data_bad) fault = 1'b1; else wr_phase = 1'b1;
          3'd1:    if (addr_bad | data_bad) fault = 1'b1; else wr_duty  = 1'b1;
          3'd2:    if (addr_bad)            fault = 1'b1; else wr_en    = 1'b1;
          3'd3:    set_swap = 1'b1;
          3'd4:    begin resp_vld = 1'b1; resp_byte = 8'(CHANNELS); end
          3'd5:    if (data_bad) fault = 1'b1; else wr_bcast = 1'b1;
          default: fault = 1'b1;
        endcase
        if (fault) begin
          resp_vld  = 1'b1;
          resp_byte = 8'hFF;
        end
      end
    end else if (rx_fire) begin
      if (rx_tdata[7]) state_d = S_B1;
      else begin
        case (state)
          S_B1:    state_d = S_B2;
          S_B2:    state_d = S_B3;
`ifdef PA_CHECKSUM_EN
          S_B3:    state_d = S_CK;
          S_CK:    state_d = S_EXEC;
`else
          S_B3:    state_d = S_EXEC;
`endif
          default: state_d = state;
        endcase
      end
    end
  end

  // period counter, sync reference, swap request and pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      sync_out  <= 1'b0;
      swap_pend <= 1'b0;
      swap_out  <= 1'b0;
    end else begin
      cnt       <= wrap ? '0 : cnt + 1'b1;
      sync_out  <= cnt < PHASE_W'(PERIOD / 2);
      swap_out  <= swap_now;
      // a SWAP landing on the wrap edge arms the following wrap
      swap_pend <= set_swap | (swap_pend & ~wrap);
    end
  end

  // response byte held until the UART takes it; sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_tvalid <= 1'b0;
      tx_tdata  <= 8'h00;
      err_out   <= 1'b0;
    end else begin
      if (resp_vld) begin
        tx_tvalid <= 1'b1;
        tx_tdata  <= resp_byte;
      end else if (tx_tvalid & tx_tready) begin
        tx_tvalid <= 1'b0;
      end
      err_out <= err_out | fault;
    end
  end

  for (genvar j = 0; j < CHANNELS; j++) begin : g_chan
    logic sel;
    assign sel = addr_q == 7'(j);
    pa_chan #(.PHASE_W(PHASE_W), .PERIOD(PERIOD)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .cnt      (cnt),
      .wr_phase (wr_bcast | (wr_phase & sel)),
      .wr_duty  (wr_duty & sel),
      .wr_en    (wr_en & sel),
      .wdata    (wdata),
      .en_bit   (d2_q[0]),
      .swap     (swap_now),
      .tx       (tx[j])
    );
  end
endmodule

// File: doc/phase_array_ctrl.md
# phase_array_ctrl

Next-generation transducer-array phase controller. It generates `CHANNELS` square-wave drive outputs from one shared period counter, each with its own phase, duty and enable. Per-channel settings are double-buffered in shadow and active banks, and the swap between them happens only at a period boundary. Commands arrive as a framed byte stream over an AXI-stream-style byte interface driven by the board UART, which also takes the responses.

## Interface
Parameters:
- `CHANNELS`, 88: number of drive outputs, 1..128.
- `PHASE_W`, 11: width of the period counter, phase and duty fields.
- `PERIOD`, 1250: counter modulus in clk cycles (50 MHz / 40 kHz); must satisfy 2 ≤ `PERIOD` ≤ 2^`PHASE_W`.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `rx_tdata`, in, 8: command byte.
- `rx_tvalid`, in, 1: command byte valid.
- `rx_tready`, out, 1: block accepts a command byte.
- `tx_tdata`, out, 8: response byte.
- `tx_tvalid`, out, 1: response byte valid.
- `tx_tready`, in, 1: UART accepts the response byte.
- `sync_out`, out, 1: zero-phase reference square wave, for board-to-board sync.
- `swap_out`, out, 1: one-cycle pulse when the active bank is loaded.
- `tx`, out, `CHANNELS`: transducer drive outputs.
- `err_out`, out, 1: sticky error flag; cleared only by reset.

## Operation
Period counter:
- `cnt` counts 0..`PERIOD`-1 and wraps to 0.
- `sync_out` = (`cnt` < `PERIOD`/2), registered.

Per-channel output:
- d = (`cnt` − `phase[j]`) mod `PERIOD`, computed without overflow for any `PHASE_W`.
- `tx[j]` = `en[j]` & (d < `duty[j]`), using active-bank values, registered.
- duty 0 gives a constant low output; a duty equal to `PERIOD` is rejected as an error.

Banks:
- The shadow bank (`phase`, `duty`, `en`) is written by commands.
- When `swap_pend` is set and `cnt` == `PERIOD`-1, the whole shadow bank is copied to the active bank on that edge. At the same edge `swap_pend` clears and `swap_out` pulses.

Frame format:
- Byte 0 is the opcode byte: bit 7 = 1, bits [6:4] = op, bits [3:0] ignored.
- Bytes 1..3 are payload bytes with bit 7 = 0: ADDR[6:0], D1[6:0], D2[6:0].
- DATA = {D1, D2}, 14 bits.
- Any byte with bit 7 = 1 restarts a frame; a partially received frame is discarded silently.
- A payload byte received in IDLE is dropped.

Parser FSM:
- States: IDLE → B1 → B2 → B3 → EXEC → IDLE.
- With `PA_CHECKSUM_EN` defined, an extra state CK sits between B3 and EXEC.
- EXEC lasts one cycle.

Ops:
- 0, SET_PHASE: `phase[ADDR]` ← DATA.
- 1, SET_DUTY: `duty[ADDR]` ← DATA.
- 2, SET_EN: `en[ADDR]` ← DATA[0].
- 3, SWAP: sets `swap_pend`; ADDR and DATA are ignored.
- 4, QUERY: response byte = `CHANNELS`.
- 5, BCAST_PHASE: every channel's `phase` ← DATA; ADDR is ignored.
- 6, 7: unknown op.

Errors:
- Conditions: ADDR ≥ `CHANNELS` (ops 0–2), DATA ≥ `PERIOD` (ops 0, 1, 5), or an unknown op.
- On error: no state change, response 0xFF, `err_out` set.
- A valid write or swap sends no response.

## Timing
Reset values:
- `cnt` = 0 and `sync_out` = 0 while `rst` is asserted; from the first edge after release `sync_out` = 1 (since `cnt` = 0).
- All outputs in `tx` = 0.
- Both banks: phase 0, duty `PERIOD`/2, en 0.
- `swap_pend` = 0, `swap_out` = 0, `err_out` = 0.
- `tx_tvalid` = 0, `tx_tdata` = 0, `rx_tready` = 1.
- FSM in IDLE.

Handshakes:
- A byte transfers when `rx_tvalid` & `rx_tready`.
- `rx_tready` = 0 while in EXEC or while `tx_tvalid` is set.
- A response is held stable until `tx_tready` is seen; `tx_tvalid` drops on the edge after the handshake.

Latency:
- A shadow write lands on the edge that leaves EXEC, which is 1 cycle after byte 3 (or the checksum byte) is accepted.
- QUERY and error responses assert `tx_tvalid` on that same edge.
- Active → `tx` latency is 1 cycle (the output register).

Simultaneous events:
- A shadow write on the same edge as a swap: the swap copies the pre-write shadow value, and the write lands in shadow only.
- SWAP executed on a wrap edge sets `swap_pend` for the next wrap.
- Repeated SWAP commands before a wrap cause one swap.

Reset mid-frame: the frame is aborted, and every register takes its reset value immediately.

## Configuration
`PA_CHECKSUM_EN`:
- Defined: a fifth byte CK (bit 7 = 0) is required.
- CK[6:0] = sum of the low 7 bits of bytes 0–3, mod 128.
- On mismatch: the frame is discarded, response 0xFD, `err_out` set.
- Undefined: 4-byte frames, and the CK state is absent.

## Test plan
- Reset release:
  - `tx` = 0, `tx_tvalid` = 0.
  - `sync_out` high for 625 cycles, then low for 625.
  - `swap_out` never pulses.
- Set channel 5 to phase 100, duty 625 and en 1, then SWAP:
  - `swap_out` pulses once, at the edge where `cnt` goes 1249→0.
  - From then `tx[5]` rises 101 cycles after each `cnt` = 0 and stays high 625 cycles.
  - Other channels stay at 0.
- Edge cases:
  - Phase 1200 with duty 100: `tx` is high across the wrap (d wraps mod 1250).
  - Duty 0: `tx` is constantly low.
  - SET_DUTY with DATA 1250: response 0xFF, `err_out` = 1, no change.
- Framing:
  - QUERY with `tx_tready` held low for 50 cycles: `tx_tdata` = 88 held stable, and `rx_tready` = 0 throughout.
  - Opcode byte injected after B2: the partial frame is dropped, no write occurs, and the new frame executes.
- Bank timing:
  - SET_PHASE sent on the wrap edge with `swap_pend` set: the active bank keeps the old value, and the new value appears after the next SWAP.
- Checksum, with `PA_CHECKSUM_EN` defined:
  - Correct CK: the write occurs.
  - CK off by 1: response 0xFD, no write.
